idct_matmul_engine: RTL and testbench
=====================================

Name: idct_matmul_engine

Overview:
- Parametrised matrix-multiply engine for one NxN block pass of the 2-D IDCT in the image decompressor.
- It reads an NxN operand A from a dual-port RAM (source port) and multiplies it by the coefficient matrix C. Coefficients come from an external combinational lookup.
- It writes the NxN result to a second RAM (destination port).
- mode selects the pass: row pass T = A*C, or column pass S = C^T*A with optional 0..255 clipping. Both passes of the decoder use one instance, which replaces the hard-coded 8x8 / 2-multiplier datapath.

Parameters:
- N, 8: block dimension; power of 2, >= 2.
- MULTS, 2: multipliers, i.e. products summed per cycle; must divide N.
- DATA_W, 32: RAM word width; operands are signed.
- COEF_W, 16: signed coefficient width.
- AW, 7: RAM address width.
- SHIFT_ROW, 8: arithmetic right shift applied in mode 0.
- SHIFT_COL, 16: arithmetic right shift applied in mode 1.
- IDX_W = log2(N): derived; not overridable.

Ports:
- Clock  in  1  clock
- Resetn  in  1  asynchronous reset, active-low
- start  in  1  begin a block pass; sampled only in IDLE
- mode  in  1  0 = row pass (A*C), 1 = column pass (C^T*A); latched on start
- clip_en  in  1  saturate mode-1 results to 0..255; latched on start
- src_base  in  AW  base address of A; latched on start
- dst_base  in  AW  base address of result; latched on start
- src_addr  out  AW  source RAM read address; RAM read latency is exactly 1 cycle
- src_rdata  in  DATA_W  source RAM read data
- dst_addr  out  AW  destination write address
- dst_wdata  out  DATA_W  destination write data
- dst_we  out  1  destination write enable, one-cycle pulses
- coef_k  out  MULTS*IDX_W  lane m row index k
- coef_n  out  IDX_W  coefficient column, equal to the current output index o
- coef_data  in  MULTS*COEF_W  lane m = C[coef_k[m]][coef_n], combinational, same cycle
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the last result is written

Behaviour:
- Reset values: src_addr=0, dst_addr=0, dst_wdata=0, dst_we=0, coef_k=0, coef_n=0, busy=0, done=0. State=IDLE; accumulator and vector buffer are cleared.
- Reset is asynchronous and may arrive at any cycle, including mid-pass. It aborts the pass with no further writes; the next start begins a fresh pass.
- Vector v = 0..N-1:
  - mode 0: A row v; address src_base + v*N + k.
  - mode 1: A column v; address src_base + k*N + v.
- State IDLE:
  - start=1 latches mode, clip_en and bases, sets v=0, goes to LOAD.
  - start is ignored in every other state; it is not queued.
- State LOAD (N+1 cycles):
  - Issues reads for k=0..N-1 on consecutive cycles.
  - Captures src_rdata into buf[k] one cycle after each read.
  - After capturing buf[N-1], goes to CALC.
- State CALC (N*N/MULTS cycles):
  - For output o=0..N-1 and group g=0..N/MULTS-1: lane m uses k = g*MULTS+m.
  - Each cycle: acc <= (g==0 ? 0 : acc) + sum over m of buf[k]*coef_data[m].
  - Full precision: products DATA_W+COEF_W bits, accumulator DATA_W+COEF_W+IDX_W bits.
  - In the cycle after the last group of output o, dst_we=1 with result(o).
  - That write overlaps the first group of o+1.
- State WRITE (1 cycle):
  - Writes the result for o=N-1.
  - If v<N-1: v++ and go to LOAD.
  - Otherwise go to DONE.
- State DONE (1 cycle): done=1, busy=0, then IDLE.
- Result arithmetic: r = acc >>> (mode ? SHIFT_COL : SHIFT_ROW), truncated to DATA_W.
- Clipping: if mode=1 and clip_en=1, r<0 gives 0 and r>255 gives 255. mode 0 never clips.
- Destination address: mode 0 writes dst_base + v*N + o; mode 1 writes dst_base + o*N + v.
- Latency: done is asserted exactly N*(N+2+N*N/MULTS)+1 cycles after the start-sampling edge. For N=8, MULTS=2 this is 337.
- Write count: exactly N*N dst_we pulses per pass, never two in one cycle. src_addr is don't-care outside LOAD.
- Address arithmetic wraps modulo 2^AW with no error flag.

Test Plan:
- Row identity (N=8, MULTS=2): C=256*I, A[i][j]=i*8+j-20, mode 0 -> dst holds A exactly; 64 writes; done 337 cycles after start.
- Column identity: C=256*I, A[k][j]=256*(k*8+j), mode 1, clip_en=0 -> dst[i*8+j]=i*8+j. Also check write order is column-major (v outer loop).
- Clipping: mode 1, clip_en=1, C=256*I, A entries 256*{-5, 0, 128, 300} -> results {0, 0, 128, 255}. The same with clip_en=0 gives {-5, 0, 128, 300}.
- Real DCT coefficients: random signed 16-bit A, full pass mode 0 then mode 1 -> matches a bit-exact reference model, including negative truncation of >>>.
- Parameter sweep, N=4 with MULTS=1, 2, 4 -> results identical; done latency 4*(6+16/MULTS)+1 = 89, 57 and 41 cycles.
- Control: start pulsed while busy -> ignored, with no extra writes. Resetn asserted mid-CALC -> all outputs return to reset values immediately; a following start completes a correct pass.

Source files
------------

// File: rtl/idct_matmul_engine.sv
// One NxN block pass of the 2-D IDCT: row pass T = A*C or column pass S = C^T*A,
// with MULTS products accumulated per cycle and optional 0..255 clipping on the column pass.
module idct_matmul_engine #(
    parameter int N         = 8,
    parameter int MULTS     = 2,
    parameter int DATA_W    = 32,
    parameter int COEF_W    = 16,
    parameter int AW        = 7,
    parameter int SHIFT_ROW = 8,
    parameter int SHIFT_COL = 16
) (
    input  logic                         Clock,
    input  logic                         Resetn,
    input  logic                         start,
    input  logic                         mode,
    input  logic                         clip_en,
    input  logic [AW-1:0]                src_base,
    input  logic [AW-1:0]                dst_base,
    output logic [AW-1:0]                src_addr,
    input  logic [DATA_W-1:0]            src_rdata,
    output logic [AW-1:0]                dst_addr,
    output logic [DATA_W-1:0]            dst_wdata,
    output logic                         dst_we,
    output logic [MULTS*$clog2(N)-1:0]   coef_k,
    output logic [$clog2(N)-1:0]         coef_n,
    input  logic [MULTS*COEF_W-1:0]      coef_data,
    output logic                         busy,
    output logic                         done
);

    localparam int IDX_W  = $clog2(N);
    localparam int NG     = N / MULTS;
    localparam int GW     = (NG > 1) ? $clog2(NG) : 1;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + IDX_W;

    localparam logic [IDX_W:0]             LOAD_LAST = (IDX_W+1)'(N);
    localparam logic [IDX_W-1:0]           IDX_LAST  = IDX_W'(N - 1);
    localparam logic [GW-1:0]              G_LAST    = GW'(NG - 1);
    localparam logic signed [DATA_W-1:0]   PIX_MAX   = DATA_W'(255);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_WRITE, S_DONE} state_t;

    state_t                     state_r;
    logic                       mode_r;
    logic                       clip_r;
    logic [AW-1:0]              src_base_r;
    logic [AW-1:0]              dst_base_r;
    logic [IDX_W-1:0]           v_r;
    logic [IDX_W:0]             cnt_r;
    logic [IDX_W-1:0]           o_r;
    logic [GW-1:0]              g_r;
    logic signed [DATA_W-1:0]   vec_r [N];
    logic signed [ACC_W-1:0]    acc_r;

    logic signed [COEF_W-1:0]   coef_s;
    logic signed [PROD_W-1:0]   prod_s;
    logic signed [ACC_W-1:0]    sum_s;
    logic signed [ACC_W-1:0]    acc_next_s;
    logic signed [ACC_W-1:0]    shifted_s;
    logic signed [DATA_W-1:0]   trunc_s;
    logic signed [DATA_W-1:0]   result_s;

    // N is a power of two, so hi*N + lo is just the concatenation {hi, lo}.
    function automatic logic [AW-1:0] blk_addr(input logic [AW-1:0] base,
                                               input logic [IDX_W-1:0] hi,
                                               input logic [IDX_W-1:0] lo);
        return base + AW'({hi, lo});
    endfunction

    function automatic logic [MULTS*IDX_W-1:0] group_lanes(input logic [GW-1:0] g);
        logic [MULTS*IDX_W-1:0] lanes;
        lanes = '0;
        for (int m = 0; m < MULTS; m++) begin
            lanes[m*IDX_W +: IDX_W] = IDX_W'(int'(g) * MULTS + m);
        end
        return lanes;
    endfunction

    // Multiply-accumulate for the current group, then scale, truncate and optionally clip.
    always_comb begin
        sum_s  = '0;
        prod_s = '0;
        coef_s = '0;
        for (int m = 0; m < MULTS; m++) begin
            coef_s = coef_data[m*COEF_W +: COEF_W];
            prod_s = vec_r[coef_k[m*IDX_W +: IDX_W]] * coef_s;
            sum_s  = sum_s + ACC_W'(prod_s);
        end
        if (g_r == '0) begin
            acc_next_s = sum_s;
        end else begin
            acc_next_s = acc_r + sum_s;
        end
        if (mode_r) begin
            shifted_s = acc_next_s >>> SHIFT_COL;
        end else begin
            shifted_s = acc_next_s >>> SHIFT_ROW;
        end
        trunc_s = shifted_s[DATA_W-1:0];
        if (mode_r && clip_r) begin
            if (trunc_s[DATA_W-1]) begin
                result_s = '0;
            end else if (trunc_s > PIX_MAX) begin
                result_s = PIX_MAX;
            end else begin
                result_s = trunc_s;
            end
        end else begin
            result_s = trunc_s;
        end
    end

    // Pass sequencer with registered RAM, coefficient and status outputs.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_r    <= S_IDLE;
            mode_r     <= 1'b0;
            clip_r     <= 1'b0;
            src_base_r <= '0;
            dst_base_r <= '0;
            v_r        <= '0;
            cnt_r      <= '0;
            o_r        <= '0;
            g_r        <= '0;
            acc_r      <= '0;
            for (int i = 0; i < N; i++) vec_r[i] <= '0;
            src_addr   <= '0;
            dst_addr   <= '0;
            dst_wdata  <= '0;
            dst_we     <= 1'b0;
            coef_k     <= '0;
            coef_n     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            dst_we <= 1'b0;
            done   <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        mode_r     <= mode;
                        clip_r     <= clip_en;
                        src_base_r <= src_base;
                        dst_base_r <= dst_base;
                        v_r        <= '0;
                        cnt_r      <= '0;
                        src_addr   <= src_base;
                        busy       <= 1'b1;
                        state_r    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Read data trails the address by one cycle.
                    if (cnt_r != '0) begin
                        vec_r[IDX_W'(cnt_r - 1'b1)] <= src_rdata;
                    end
                    if (cnt_r == LOAD_LAST) begin
                        cnt_r   <= '0;
                        g_r     <= '0;
                        o_r     <= '0;
                        coef_k  <= group_lanes('0);
                        coef_n  <= '0;
                        state_r <= S_CALC;
                    end else begin
                        cnt_r    <= cnt_r + 1'b1;
                        src_addr <= mode_r ? blk_addr(src_base_r, IDX_W'(cnt_r + 1'b1), v_r)
                                           : blk_addr(src_base_r, v_r, IDX_W'(cnt_r + 1'b1));
                    end
                end
                S_CALC: begin
                    acc_r <= acc_next_s;
                    if (g_r == G_LAST) begin
                        dst_we    <= 1'b1;
                        dst_wdata <= result_s;
                        dst_addr  <= mode_r ? blk_addr(dst_base_r, o_r, v_r)
                                            : blk_addr(dst_base_r, v_r, o_r);
                        g_r       <= '0;
                        if (o_r == IDX_LAST) begin
                            state_r <= S_WRITE;
                        end else begin
                            o_r    <= o_r + 1'b1;
                            coef_n <= o_r + 1'b1;
                            coef_k <= group_lanes('0);
                        end
                    end else begin
                        g_r    <= g_r + 1'b1;
                        coef_k <= group_lanes(g_r + 1'b1);
                    end
                end
                S_WRITE: begin
                    if (v_r == IDX_LAST) begin
                        state_r <= S_DONE;
                    end else begin
                        v_r      <= v_r + 1'b1;
                        cnt_r    <= '0;
                        src_addr <= mode_r ? blk_addr(src_base_r, '0, v_r + 1'b1)
                                           : blk_addr(src_base_r, v_r + 1'b1, '0);
                        state_r  <= S_LOAD;
                    end
                end
                S_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_idct_matmul_engine.sv
// Directed and randomised passes of idct_matmul_engine, checked against a plain
// matrix-product reference model; also three N=4 instances for the MULTS sweep.
module tb_idct_matmul_engine;

    logic        Clock, Resetn, start, mode, clip_en;
    logic [6:0]  src_base, dst_base, src_addr, dst_addr;
    logic [31:0] src_rdata, dst_wdata, coef_data;
    logic        dst_we, busy, done;
    logic [5:0]  coef_k;
    logic [2:0]  coef_n;

    int          cmat [8][8];
    longint      amat [8][8];
    longint      emat [8][8];
    logic [31:0] smem [128];
    logic [6:0]  wa_q [$];
    logic [31:0] wd_q [$];
    logic [6:0]  ea_q [$];
    logic [31:0] ed_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    logic        start4;
    int          c4mat [4][4];
    longint      a4 [4][4];
    logic [31:0] smem4 [128];

    idct_matmul_engine #(.N(8), .MULTS(2)) dut (
        .Clock(Clock), .Resetn(Resetn), .start(start), .mode(mode), .clip_en(clip_en),
        .src_base(src_base), .dst_base(dst_base), .src_addr(src_addr), .src_rdata(src_rdata),
        .dst_addr(dst_addr), .dst_wdata(dst_wdata), .dst_we(dst_we),
        .coef_k(coef_k), .coef_n(coef_n), .coef_data(coef_data), .busy(busy), .done(done)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    always_comb begin
        coef_data = '0;
        for (int m = 0; m < 2; m++) coef_data[m*16 +: 16] = 16'(cmat[coef_k[m*3 +: 3]][coef_n]);
    end

    always @(posedge Clock) src_rdata <= smem[src_addr];

    always @(posedge Clock) begin
        if (dst_we) begin
            wa_q.push_back(dst_addr);
            wd_q.push_back(dst_wdata);
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : sw
        localparam int M = 1 << gi;
        logic [6:0]      sa, da;
        logic [31:0]     rd, wd;
        logic            we, bz, dn;
        logic [M*2-1:0]  ck;
        logic [1:0]      cn;
        logic [M*16-1:0] cd;
        logic [31:0]     dm [128];
        int              wcnt = 0;

        always_comb begin
            cd = '0;
            for (int m = 0; m < M; m++) cd[m*16 +: 16] = 16'(c4mat[ck[m*2 +: 2]][cn]);
        end

        always @(posedge Clock) rd <= smem4[sa];

        always @(posedge Clock) begin
            if (we) begin
                dm[da] <= wd;
                wcnt   <= wcnt + 1;
            end
        end

        idct_matmul_engine #(.N(4), .MULTS(M)) u (
            .Clock(Clock), .Resetn(Resetn), .start(start4), .mode(1'b0), .clip_en(1'b0),
            .src_base(7'd0), .dst_base(7'd16), .src_addr(sa), .src_rdata(rd),
            .dst_addr(da), .dst_wdata(wd), .dst_we(we),
            .coef_k(ck), .coef_n(cn), .coef_data(cd), .busy(bz), .done(dn)
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " src_addr"}, src_addr, 0);
        chk({tag, " dst_addr"}, dst_addr, 0);
        chk({tag, " dst_wdata"}, dst_wdata, 0);
        chk({tag, " dst_we"}, dst_we, 0);
        chk({tag, " coef_k"}, coef_k, 0);
        chk({tag, " coef_n"}, coef_n, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
    endtask

    task automatic load_a(input logic [6:0] sb);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) smem[7'(sb + i*8 + j)] = 32'(amat[i][j]);
    endtask

    // Reference: T = A*C (mode 0) or S = C^T*A (mode 1), written v-major.
    task automatic build_exp(input logic md, input logic ce, input logic [6:0] db);
        longint acc;
        int     r;
        ea_q.delete();
        ed_q.delete();
        for (int v = 0; v < 8; v++) begin
            for (int o = 0; o < 8; o++) begin
                acc = 0;
                for (int k = 0; k < 8; k++)
                    acc += (md ? amat[k][v] : amat[v][k]) * longint'(cmat[k][o]);
                r = int'(acc >>> (md ? 16 : 8));
                if (md && ce) r = (r < 0) ? 0 : ((r > 255) ? 255 : r);
                if (md) emat[o][v] = r;
                else    emat[v][o] = r;
                ea_q.push_back(7'(db + (md ? o*8 + v : v*8 + o)));
                ed_q.push_back(32'(r));
            end
        end
    endtask

    task automatic run_pass(input logic md, input logic ce, input logic [6:0] sb,
                            input logic [6:0] db, input int glitch, output int lat);
        wa_q.delete();
        wd_q.delete();
        @(negedge Clock);
        mode = md; clip_en = ce; src_base = sb; dst_base = db; start = 1'b1;
        @(posedge Clock);
        #1 start = 1'b0;
        chk("busy after start", busy, 1);
        lat = 0;
        for (int c = 1; c <= 2000; c++) begin
            @(posedge Clock);
            #1 start = (c == glitch);
            if (done) begin
                lat = c;
                break;
            end
        end
        start = 1'b0;
        repeat (10) @(posedge Clock);
        #1 chk("idle after pass", {busy, done}, 0);
    endtask

    task automatic check_pass(input string tag, input int lat);
        chk({tag, " latency"}, lat, 337);
        chk({tag, " write count"}, wa_q.size(), 64);
        for (int i = 0; i < 64; i++) begin
            if (i < wa_q.size()) begin
                chk($sformatf("%s addr[%0d]", tag, i), wa_q[i], ea_q[i]);
                chk($sformatf("%s data[%0d]", tag, i), wd_q[i], ed_q[i]);
            end
        end
    endtask

    initial begin
        int lat;
        int vals [4];
        int l0, l1, l2;
        longint acc4;
        logic [31:0] e4;
        real s;

        vals = '{-5, 0, 128, 300};
        Resetn = 1'b0; start = 1'b0; mode = 1'b0; clip_en = 1'b0;
        src_base = '0; dst_base = '0; start4 = 1'b0;
        for (int i = 0; i < 128; i++) begin smem[i] = '0; smem4[i] = '0; end
        repeat (3) @(posedge Clock);
        #1 chk_reset_outputs("reset");
        @(negedge Clock) Resetn = 1'b1;

        // Row identity, with a stray start pulse mid-pass.
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                cmat[i][j] = (i == j) ? 256 : 0;
                amat[i][j] = i*8 + j - 20;
            end
        load_a(7'd0);
        build_exp(1'b0, 1'b0, 7'd64);
        run_pass(1'b0, 1'b0, 7'd0, 7'd64, 50, lat);
        check_pass("row_identity", lat);

        // Column identity: dst[i*8+j] = i*8+j, column-major write order.
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) amat[i][j] = 256 * (i*8 + j);
        load_a(7'd64);
        build_exp(1'b1, 1'b0, 7'd0);
        run_pass(1'b1, 1'b0, 7'd64, 7'd0, 0, lat);
        check_pass("col_identity", lat);

        // Clipping on and off.
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) amat[i][j] = 256 * vals[(i*8 + j) % 4];
        load_a(7'd0);
        build_exp(1'b1, 1'b1, 7'd0);
        run_pass(1'b1, 1'b1, 7'd0, 7'd0, 0, lat);
        check_pass("clip_on", lat);
        build_exp(1'b1, 1'b0, 7'd0);
        run_pass(1'b1, 1'b0, 7'd0, 7'd0, 0, lat);
        check_pass("clip_off", lat);

        // DCT coefficients, random A: row pass into a wrapping region, then column pass.
        for (int k = 0; k < 8; k++)
            for (int o = 0; o < 8; o++) begin
                s = (k == 0) ? 0.35355339059 : 0.5;
                cmat[k][o] = $rtoi(s * $cos((2*o + 1) * k * 3.14159265358979 / 16.0) * 8192.0);
            end
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) amat[i][j] = longint'($signed(16'($urandom)));
        load_a(7'd0);
        build_exp(1'b0, 1'b0, 7'd100);
        run_pass(1'b0, 1'b0, 7'd0, 7'd100, 0, lat);
        check_pass("dct_row", lat);
        for (int i = 0; i < wa_q.size(); i++) smem[wa_q[i]] = wd_q[i];
        amat = emat;
        build_exp(1'b1, 1'b0, 7'd0);
        run_pass(1'b1, 1'b0, 7'd100, 7'd0, 0, lat);
        check_pass("dct_col", lat);

        // Reset in the middle of CALC, then a fresh pass.
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) amat[i][j] = longint'($signed(16'($urandom)));
        load_a(7'd0);
        @(negedge Clock);
        mode = 1'b0; clip_en = 1'b0; src_base = 7'd0; dst_base = 7'd32; start = 1'b1;
        @(posedge Clock);
        #1 start = 1'b0;
        repeat (14) @(posedge Clock);
        @(negedge Clock) Resetn = 1'b0;
        #1 chk_reset_outputs("mid_reset");
        wa_q.delete();
        repeat (5) @(posedge Clock);
        #1 chk("writes during reset", wa_q.size(), 0);
        @(negedge Clock) Resetn = 1'b1;
        build_exp(1'b0, 1'b0, 7'd32);
        run_pass(1'b0, 1'b0, 7'd0, 7'd32, 0, lat);
        check_pass("after_reset", lat);

        // N=4 sweep over MULTS = 1, 2, 4.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                a4[i][j]    = longint'($signed(16'($urandom)));
                c4mat[i][j] = int'($signed(12'($urandom)));
                smem4[i*4 + j] = 32'(a4[i][j]);
            end
        @(negedge Clock) start4 = 1'b1;
        @(posedge Clock);
        #1 start4 = 1'b0;
        l0 = 0; l1 = 0; l2 = 0;
        for (int c = 1; c <= 300; c++) begin
            @(posedge Clock);
            #1;
            if (sw[0].dn && l0 == 0) l0 = c;
            if (sw[1].dn && l1 == 0) l1 = c;
            if (sw[2].dn && l2 == 0) l2 = c;
            if (l0 != 0 && l1 != 0 && l2 != 0) break;
        end
        chk("sweep m1 latency", l0, 89);
        chk("sweep m2 latency", l1, 57);
        chk("sweep m4 latency", l2, 41);
        chk("sweep m1 writes", sw[0].wcnt, 16);
        chk("sweep m2 writes", sw[1].wcnt, 16);
        chk("sweep m4 writes", sw[2].wcnt, 16);
        for (int v = 0; v < 4; v++)
            for (int o = 0; o < 4; o++) begin
                acc4 = 0;
                for (int k = 0; k < 4; k++) acc4 += a4[v][k] * longint'(c4mat[k][o]);
                e4 = 32'(acc4 >>> 8);
                chk($sformatf("sweep m1 T[%0d][%0d]", v, o), sw[0].dm[16 + v*4 + o], e4);
                chk($sformatf("sweep m2 T[%0d][%0d]", v, o), sw[1].dm[16 + v*4 + o], e4);
                chk($sformatf("sweep m4 T[%0d][%0d]", v, o), sw[2].dm[16 + v*4 + o], e4);
            end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
